// File: rtl/elevator_controller.sv
// Four-floor elevator car controller.
// Latches call buttons, drives the hoist motor toward outstanding calls,
// holds the door open for a fixed dwell at each stop, and locks out on a
// shaft sensor fault until reset.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | car parked, choosing the next action from pending calls
// MOVE_UP   | motor_up driven, stopping at the first floor with a call
// MOVE_DOWN | motor_down driven, stopping at the first floor with a call
// DOOR      | door open for DOOR_CYCLES cycles, restarted by a call here
// FAULT     | inconsistent shaft sensors; everything off until reset
module elevator_controller #(
   parameter int DOOR_CYCLES = 100
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [3:0] floor_sensor,
   input  logic [3:0] call_req,
   output logic       motor_up,
   output logic       motor_down,
   output logic       door_open,
   output logic [1:0] current_floor,
   output logic [3:0] call_pending,
   output logic       fault
);

   localparam int CW = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      MOVE_UP   = 3'd1,
      MOVE_DOWN = 3'd2,
      DOOR      = 3'd3,
      FAULT     = 3'd4
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] door_cnt, door_cnt_next;
   logic [3:0]    pending_next;
   logic [3:0]    calls;
   logic [3:0]    above_mask, below_mask;
   logic          sensor_valid, sensor_fault;
   logic [1:0]    sensed_floor, floor_now;
   logic          calls_above, calls_below;

   // Decode the shaft sensors: one-hot is a valid floor, several bits a fault.
   always_comb begin
      sensor_fault = (floor_sensor & (floor_sensor - 4'd1)) != 4'd0;
      sensor_valid = (floor_sensor != 4'd0) && !sensor_fault;
      sensed_floor = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (floor_sensor[i]) sensed_floor = 2'(i);
      end
   end

   // Direction masks relative to where the car is (or last was).
   // Live buttons are merged in so a call acts one cycle after it appears.
   always_comb begin
      floor_now  = sensor_valid ? sensed_floor : current_floor;
      calls      = call_pending | call_req;
      above_mask = 4'd0;
      below_mask = 4'd0;
      for (int i = 0; i < 4; i++) begin
         above_mask[i] = (i > int'(floor_now));
         below_mask[i] = (i < int'(floor_now));
      end
      calls_above = |(calls & above_mask);
      calls_below = |(calls & below_mask);
   end

   // Next-state and door dwell timer; a sensor fault overrides everything.
   always_comb begin
      state_next    = state;
      door_cnt_next = door_cnt;
      case (state)
         IDLE: begin
            if (sensor_valid && calls[sensed_floor]) begin
               state_next    = DOOR;
               door_cnt_next = DOOR_LOAD;
            end else if (calls_above) begin
               state_next = MOVE_UP;
            end else if (calls_below) begin
               state_next = MOVE_DOWN;
            end
         end
         MOVE_UP: begin
            // At floor 3 nothing lies above, so the car always stops there.
            if (sensor_valid) begin
               if (calls[sensed_floor]) begin
                  state_next    = DOOR;
                  door_cnt_next = DOOR_LOAD;
               end else if (!calls_above) begin
                  state_next = IDLE;
               end
            end
         end
         MOVE_DOWN: begin
            if (sensor_valid) begin
               if (calls[sensed_floor]) begin
                  state_next    = DOOR;
                  door_cnt_next = DOOR_LOAD;
               end else if (!calls_below) begin
                  state_next = IDLE;
               end
            end
         end
         DOOR: begin
            // A button press at this floor keeps the door open longer.
            if (call_req[current_floor]) begin
               door_cnt_next = DOOR_LOAD;
            end else if (door_cnt == '0) begin
               state_next = IDLE;
            end else begin
               door_cnt_next = door_cnt - 1'b1;
            end
         end
         FAULT: state_next = FAULT;
         default: begin
            state_next    = IDLE;
            door_cnt_next = '0;
         end
      endcase
      if (sensor_fault) begin
         state_next    = FAULT;
         door_cnt_next = '0;
      end
   end

   // Call latching: calls at the open-door floor are absorbed, and the
   // stop floor is cleared on DOOR entry even if its button is pressed.
   always_comb begin
      pending_next = call_pending | call_req;
      if (state == DOOR) pending_next[current_floor] = call_pending[current_floor];
      if (state != DOOR && state_next == DOOR) pending_next[sensed_floor] = 1'b0;
   end

   // State, timer and registered outputs.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         door_cnt      <= '0;
         current_floor <= 2'd0;
         call_pending  <= 4'd0;
         motor_up      <= 1'b0;
         motor_down    <= 1'b0;
         door_open     <= 1'b0;
         fault         <= 1'b0;
      end else begin
         state         <= state_next;
         door_cnt      <= door_cnt_next;
         call_pending  <= pending_next;
         if (sensor_valid) current_floor <= sensed_floor;
         motor_up      <= (state_next == MOVE_UP);
         motor_down    <= (state_next == MOVE_DOWN);
         door_open     <= (state_next == DOOR);
         fault         <= (state_next == FAULT);
      end
   end

endmodule

// File: doc/elevator_controller.md
ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

Interface
REQ-001 SHALL have parameter: DOOR_CYCLES, 100, number of clock cycles door_open stays asserted per stop (min 2).
REQ-002 SHALL have port: CLOCK_50  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: floor_sensor  input  4  shaft sensors, bit i = car at floor i; 0000 = between floors; >1 bit set = sensor fault.
REQ-005 SHALL have port: call_req  input  4  call buttons, bit i = request floor i; level, sampled every cycle.
REQ-006 SHALL have port: motor_up  output  1  drive car upward.
REQ-007 SHALL have port: motor_down  output  1  drive car downward.
REQ-008 SHALL have port: door_open  output  1  door open command.
REQ-009 SHALL have port: current_floor  output  2  binary index of last floor sensed.
REQ-010 SHALL have port: call_pending  output  4  latched outstanding calls, one bit per floor.
REQ-011 SHALL have port: fault  output  1  sensor fault indicator.

Function
REQ-012 All outputs SHALL be registered; decisions take effect one cycle after the inputs that cause them.
REQ-013 FSM states SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR, FAULT.
REQ-014 "Valid floor f" SHALL mean floor_sensor is exactly one-hot with bit f set; current_floor SHALL load f on every cycle a valid floor is sensed and hold when floor_sensor = 0000.
REQ-015 call_pending[i] SHALL set on the cycle after call_req[i]=1, except when in DOOR at floor i (call absorbed, timer restarted).
REQ-016 call_pending[f] SHALL clear on the cycle DOOR is entered at floor f; set and clear in the same cycle resolves to clear.
REQ-017 IDLE priority: pending at current_floor with valid floor sensed -> DOOR; else any pending above -> MOVE_UP; else any pending below -> MOVE_DOWN; else stay IDLE.
REQ-018 MOVE_UP/MOVE_DOWN SHALL assert motor_up/motor_down respectively; the other motor SHALL be 0.
REQ-019 While moving, on valid floor f: pending[f] -> DOOR; else no pending further in travel direction -> IDLE; else continue.
REQ-020 Floor arrival with 0000 in between SHALL not stop the car; motors SHALL stay on between floors.
REQ-021 Car at floor 3 in MOVE_UP, or floor 0 in MOVE_DOWN, SHALL always leave the move state (DOOR or IDLE); overrun is impossible.
REQ-022 DOOR SHALL assert door_open for exactly DOOR_CYCLES cycles using a counter, then go to IDLE with door_open=0.
REQ-023 motor_up, motor_down SHALL be 0 whenever door_open=1; motor_up and motor_down SHALL never both be 1.
REQ-024 Sensor fault (>1 bit set) in any state SHALL enter FAULT on next cycle: motors 0, door_open 0, fault 1.
REQ-025 FAULT SHALL be exited only by reset; call_pending keeps latching in FAULT.

Reset
REQ-026 On reset assertion, asynchronously: state IDLE, current_floor=0, call_pending=0000, motor_up=0, motor_down=0, door_open=0, fault=0, door counter=0.
REQ-027 Reset mid-move or mid-door SHALL abandon the operation and discard all pending calls.
REQ-028 After release, first active edge SHALL evaluate inputs from IDLE normally.

Verification
REQ-029 Reset, sensor=0001, call_req=0100 one cycle -> call_pending=0100, motor_up=1; sensor 0000 -> 0010 (motor stays 1) -> 0100: door_open=1 for 100 cycles, call_pending=0000, current_floor=2, then IDLE.
REQ-030 At floor 3 idle, calls 0001 and 0100 together -> MOVE_DOWN, stop at floor 2 first (door), then resume down to floor 0 (door), call_pending=0000.
REQ-031 In DOOR at floor 1, call_req=0010 held 5 cycles -> call_pending stays 0000, door_open extended to 100 cycles after last request.
REQ-032 While MOVE_UP, floor_sensor=0110 -> next cycle fault=1, motors 0, door_open 0; further calls latch; only reset clears fault.
REQ-033 Reset asserted during MOVE_DOWN between clock edges -> outputs all 0 immediately, call_pending=0000, current_floor=0.
REQ-034 Continuous check: motor_up&motor_down never 1; no motor with door_open=1.
